// File: rtl/mat_mul_seq_pkg.sv
// Shared types and constants for the 8x8 single-precision matrix-product sequencer.
package mat_mul_seq_pkg;

  localparam int N  = 8;
  localparam int NN = N * N;

  typedef logic [31:0] fp32_t;
  typedef fp32_t [N-1:0][N-1:0] mat_t;

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

endpackage

// File: rtl/mat_mul_seq_rbuf.sv
// 64 x 32 result buffer: one synchronous write port, one combinational read port.
module mat_mul_seq_rbuf
  import mat_mul_seq_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  fp32_t      wdata,
  input  logic [5:0] raddr,
  output fp32_t      rdata
);

  fp32_t r_mem [NN];

  // NOTE: storage arrays carry no reset; every entry is written before it is read.
  // NOTE: clocked state is always assigned with <= so all flops update together.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mat_mul_seq.sv
// Loads A and B, issues 64 row/column pairs to the dot-product engine, collects and drains C.
// Define MAT_MUL_SEQ_TRANSPOSE_EN to stream C in column-major order (C transposed).
module mat_mul_seq
  import mat_mul_seq_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  fp32_t           din,
  input  logic            din_valid,
  output logic            din_ready,
  output fp32_t [N-1:0]   row_vec,
  output fp32_t [N-1:0]   col_vec,
  output logic            vec_valid,
  input  fp32_t           res,
  input  logic            res_valid,
  output fp32_t           dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            res_overflow
);

  state_t        r_state, w_next;
  logic [6:0]    r_ld_cnt;
  logic [5:0]    r_k;
  logic [6:0]    r_rc;
  logic [5:0]    r_rd;
  mat_t          r_a, r_b;
  fp32_t [N-1:0] r_row_vec, r_col_vec;
  logic          r_vec_valid;
  logic          r_ovf;

  logic          w_ld_acc;
  logic          w_res_wr;
  logic          w_stray;
  logic          w_dout_acc;
  logic          w_last_acc;
  logic [5:0]    w_raddr;
  fp32_t         w_rdata;

  assign w_ld_acc   = din_valid && din_ready;
  assign w_res_wr   = res_valid && (r_state == ISSUE || r_state == WAIT) && (r_rc != 7'd64);
  assign w_stray    = res_valid && !w_res_wr;
  assign w_dout_acc = dout_valid && dout_ready;
  assign w_last_acc = w_dout_acc && (r_rd == 6'd63);

`ifdef MAT_MUL_SEQ_TRANSPOSE_EN
  assign w_raddr = {r_rd[2:0], r_rd[5:3]};
`else
  assign w_raddr = r_rd;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= LOAD;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    dout       = '0;
    unique case (r_state)
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid && r_ld_cnt == 7'd127) w_next = ISSUE;
      end
      ISSUE: begin
        if (r_k == 6'd63) w_next = WAIT;
      end
      WAIT: begin
        if (r_rc == 7'd64) w_next = DRAIN;
      end
      DRAIN: begin
        dout_valid = 1'b1;
        dout_last  = (r_rd == 6'd63);
        dout       = w_rdata;
        if (w_last_acc) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ld_cnt    <= '0;
      r_k         <= '0;
      r_rc        <= '0;
      r_rd        <= '0;
      r_row_vec   <= '0;
      r_col_vec   <= '0;
      r_vec_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_ld_acc) r_ld_cnt <= (r_ld_cnt == 7'd127) ? 7'd0 : r_ld_cnt + 7'd1;

      r_vec_valid <= (r_state == ISSUE);
      if (r_state == ISSUE) begin
        r_k       <= (r_k == 6'd63) ? 6'd0 : r_k + 6'd1;
        r_row_vec <= r_a[r_k[5:3]];
        for (int n = 0; n < N; n++) r_col_vec[n] <= r_b[n][r_k[2:0]];
      end

      // The final drain handshake clears both result pointers for the next block.
      if (w_last_acc) begin
        r_rc <= '0;
        r_rd <= '0;
      end else begin
        if (w_res_wr)   r_rc <= r_rc + 7'd1;
        if (w_dout_acc) r_rd <= r_rd + 6'd1;
      end

      if (w_stray) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      if (!r_ld_cnt[6]) r_a[r_ld_cnt[5:3]][r_ld_cnt[2:0]] <= din;
      else              r_b[r_ld_cnt[5:3]][r_ld_cnt[2:0]] <= din;
    end
  end

  mat_mul_seq_rbuf u_rbuf (
    .clk   (clk),
    .we    (w_res_wr),
    .waddr (r_rc[5:0]),
    .wdata (res),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  assign row_vec      = r_row_vec;
  assign col_vec      = r_col_vec;
  assign vec_valid    = r_vec_valid;
  assign res_overflow = r_ovf;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: latency-10 engine model, matrix-product reference, per-cycle compare.
module tb_mat_mul_seq;

  localparam int LAT = 10;

  logic             clk = 1'b0;
  logic             nrst;
  logic [31:0]      din;
  logic             din_valid;
  logic             din_ready;
  logic [7:0][31:0] row_vec;
  logic [7:0][31:0] col_vec;
  logic             vec_valid;
  logic [31:0]      res;
  logic             res_valid;
  logic [31:0]      dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             res_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mat_mul_seq dut (
    .clk          (clk),
    .nrst         (nrst),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .row_vec      (row_vec),
    .col_vec      (col_vec),
    .vec_valid    (vec_valid),
    .res          (res),
    .res_valid    (res_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last),
    .res_overflow (res_overflow)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // fp32 <-> real for finite normal values and zero, by repacking through double.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] b;
    if (x[30:0] == 31'd0) return 0.0;
    b = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int v);
    return r2f(real'(v));
  endfunction

  // Reference data for the block in flight.
  logic [31:0]  ma [8][8];
  logic [31:0]  mb [8][8];
  logic [255:0] exp_row_q [$];
  logic [255:0] exp_col_q [$];
  logic [31:0]  exp_c_q   [$];
  logic [31:0]  got       [64];

  task automatic prep_block(input bit ident);
    logic [31:0]  c [8][8];
    logic [255:0] rv, cv;
    real          acc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ma[i][j] = ident ? ((i == j) ? 32'h3F80_0000 : 32'd0) : i2f(int'($urandom_range(0, 18)) - 9);
        mb[i][j] = ident ? i2f(8 * i + j) : i2f(int'($urandom_range(0, 18)) - 9);
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0.0;
        for (int n = 0; n < 8; n++) acc += f2r(ma[i][n]) * f2r(mb[n][j]);
        c[i][j] = r2f(acc);
      end
    for (int k = 0; k < 64; k++) begin
      for (int n = 0; n < 8; n++) begin
        rv[n*32 +: 32] = ma[k/8][n];
        cv[n*32 +: 32] = mb[n][k%8];
      end
      exp_row_q.push_back(rv);
      exp_col_q.push_back(cv);
    end
    for (int q = 0; q < 64; q++) begin
`ifdef MAT_MUL_SEQ_TRANSPOSE_EN
      exp_c_q.push_back(c[q%8][q/8]);
`else
      exp_c_q.push_back(c[q/8][q%8]);
`endif
    end
  endtask

  // Engine model: fixed-latency dot product; can inject one stray result on request.
  logic [31:0] pipe_d [LAT];
  logic        pipe_v [LAT];
  logic        res_stray;
  int          stray_cnt  = 0;
  int          stray_seen = 0;

  initial begin
    real acc;
    res = '0; res_valid = 1'b0; res_stray = 1'b0;
    for (int i = 0; i < LAT; i++) begin pipe_d[i] = '0; pipe_v[i] = 1'b0; end
    forever begin
      @(posedge clk); #1;
      if (!nrst) begin
        for (int i = 0; i < LAT; i++) begin pipe_d[i] = '0; pipe_v[i] = 1'b0; end
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin pipe_d[i] = pipe_d[i-1]; pipe_v[i] = pipe_v[i-1]; end
        acc = 0.0;
        for (int n = 0; n < 8; n++) acc += f2r(row_vec[n]) * f2r(col_vec[n]);
        pipe_v[0] = vec_valid;
        pipe_d[0] = vec_valid ? r2f(acc) : 32'd0;
      end
      res_valid = pipe_v[LAT-1];
      res       = pipe_d[LAT-1];
      res_stray = 1'b0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        res_valid  = 1'b1;
        res        = 32'hDEAD_BEEF;
        res_stray  = 1'b1;
      end
    end
  end

  // Downstream model: 0 always ready, 1 three-cycle stall at element 5, 2 random.
  int ready_mode = 0;
  int hs_cnt     = 0;

  initial begin
    int stall_left;
    stall_left = 3;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hs_cnt == 0) stall_left = 3;
      case (ready_mode)
        1: begin
          if (hs_cnt == 5 && stall_left > 0) begin dout_ready = 1'b0; stall_left--; end
          else dout_ready = 1'b1;
        end
        2:       dout_ready = ($urandom_range(0, 3) != 0);
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // Compare process: all DUT outputs checked at the falling edge.
  int           neg_idx    = 0;
  int           acc_cnt    = 0;
  int           res_cnt    = 0;
  int           vv_run     = 0;
  int           vec_cnt    = 0;
  int           blk_done   = 0;
  int           exp_vec_at = -1;
  int           exp_dv_at  = -1;
  int           exp_dr_at  = -1;
  logic         exp_ovf    = 1'b0;
  logic         prev_vv    = 1'b0;
  logic         prev_dv    = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_last  = 1'b0;
  logic [31:0]  prev_dout  = '0;
  logic [255:0] k9_row     = '0;
  logic [255:0] k9_col     = '0;

  always @(negedge clk) begin
    neg_idx++;
    if (!nrst) begin
      acc_cnt = 0; res_cnt = 0; vv_run = 0; vec_cnt = 0; hs_cnt = 0;
      exp_vec_at = -1; exp_dv_at = -1; exp_dr_at = -1;
      exp_ovf = 1'b0; prev_vv = 1'b0; prev_dv = 1'b0; prev_stall = 1'b0;
    end else begin
      check("overflow_flag", res_overflow, exp_ovf);
      if (res_valid && res_stray) exp_ovf = 1'b1;
      if (din_ready) check("ready_exclusive", {vec_valid, dout_valid}, 2'b00);

      if (din_valid && din_ready) begin
        acc_cnt++;
        if (acc_cnt == 128) begin acc_cnt = 0; exp_vec_at = neg_idx + 2; end
      end

      if (vec_valid) begin
        if (!prev_vv) check("issue_latency", neg_idx, exp_vec_at);
        if (exp_row_q.size() == 0) check("vec_unexpected", 1'b1, 1'b0);
        else begin
          check("row_vec", row_vec, exp_row_q.pop_front());
          check("col_vec", col_vec, exp_col_q.pop_front());
        end
        if (vec_cnt == 9) begin k9_row = row_vec; k9_col = col_vec; end
        vec_cnt++;
        vv_run++;
      end else if (prev_vv) begin
        check("issue_length", vv_run, 64);
        vv_run = 0; vec_cnt = 0;
      end
      prev_vv = vec_valid;

      if (res_valid && !res_stray) begin
        res_cnt++;
        if (res_cnt == 64) begin res_cnt = 0; exp_dv_at = neg_idx + 2; end
      end

      if (dout_valid && !prev_dv) check("drain_start", neg_idx, exp_dv_at);
      if (neg_idx == exp_dr_at) check("next_block_ready", din_ready, 1'b1);
      if (prev_stall) check("drain_hold", {dout_last, dout}, {prev_last, prev_dout});
      check("dout_last", dout_last, dout_valid && hs_cnt == 63);

      if (dout_valid && dout_ready) begin
        if (exp_c_q.size() == 0) check("dout_unexpected", 1'b1, 1'b0);
        else check("dout", dout, exp_c_q.pop_front());
        got[hs_cnt] = dout;
        hs_cnt++;
        if (hs_cnt == 64) begin hs_cnt = 0; blk_done++; exp_dr_at = neg_idx + 1; end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      prev_dv    = dout_valid;
    end
  end

  // Drives A then B, 128 words; optional idle cycle before every word.
  task automatic load_words(input bit gaps);
    int t;
    for (int w = 0; w < 128; w++) begin
      if (gaps) begin din_valid = 1'b0; @(posedge clk); #1; end
      din_valid = 1'b1;
      din       = (w < 64) ? ma[w/8][w%8] : mb[(w-64)/8][w%8];
      t = 0;
      @(negedge clk);
      while (!din_ready && t < 200) begin @(negedge clk); t++; end
      if (!din_ready) begin
        check("load_accept_timeout", 1'b0, 1'b1);
        din_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    @(negedge clk);
    check("exact_128_accepts", din_ready, 1'b0);
  endtask

  task automatic wait_done();
    int target, t;
    target = blk_done + 1;
    t = 0;
    while (blk_done < target && t < 2000) begin @(negedge clk); t++; end
    check("block_done", blk_done >= target, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_block(input bit ident, input bit gaps, input int mode);
    prep_block(ident);
    ready_mode = mode;
    load_words(gaps);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    nrst = 1'b0; din = '0; din_valid = 1'b0;
    #23;
    check("reset_din_ready", din_ready, 1'b1);
    check("reset_flags", {vec_valid, dout_valid, dout_last, res_overflow}, 4'b0000);
    check("reset_row_vec", row_vec, 256'd0);
    check("reset_col_vec", col_vec, 256'd0);
    check("reset_dout", dout, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Identity A: C equals B, pinned with hand-computed words.
    run_block(1'b1, 1'b0, 0);
    check("ident_c0", got[0], 32'h0000_0000);
`ifdef MAT_MUL_SEQ_TRANSPOSE_EN
    check("ident_c1", got[1], 32'h4100_0000);
`else
    check("ident_c1", got[1], 32'h3F80_0000);
`endif
    check("ident_c9", got[9], 32'h4110_0000);
    check("ident_c63", got[63], 32'h427C_0000);
    check("k9_row_a11", k9_row[63:32], 32'h3F80_0000);
    check("k9_row_a10", k9_row[31:0], 32'h0000_0000);
    check("k9_col_b21", k9_col[95:64], 32'h4188_0000);

    run_block(1'b0, 1'b1, 1);
    run_block(1'b0, 1'b0, 2);

    // Stray result during LOAD sets a sticky flag.
    stray_cnt++;
    repeat (3) @(posedge clk);
    #1;
    check("stray_set", res_overflow, 1'b1);
    run_block(1'b0, 1'b0, 0);
    check("stray_sticky", res_overflow, 1'b1);

    // Asynchronous reset in the middle of ISSUE, then a fresh block.
    prep_block(1'b0);
    ready_mode = 0;
    load_words(1'b0);
    t = 0;
    while (vec_cnt < 20 && t < 200) begin @(negedge clk); t++; end
    check("reach_k20", vec_cnt >= 20, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("midreset_vec_valid", vec_valid, 1'b0);
    check("midreset_din_ready", din_ready, 1'b1);
    check("midreset_overflow", res_overflow, 1'b0);
    exp_row_q.delete();
    exp_col_q.delete();
    exp_c_q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    run_block(1'b0, 1'b0, 0);
    check("final_overflow_clear", res_overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_mul_seq.md
# mat_mul_seq

Sequencer that drives the 8-lane floating-point dot-product engine and collects its results, performing one 8x8 by 8x8 single-precision matrix product C = A·B per block. It loads A and B from a 32-bit word stream and issues 64 (row of A, column of B) vector pairs on consecutive cycles. It gathers the 64 returned dot products into a result buffer and drains C as a ready/valid word stream. It sits between the block buffer and the dot-product engine in each DCT pass of the JPEG pipeline.

## Interface
- N, 8, matrix dimension; fixed at 8, and no other value is supported.
- clk  input  1  clock; all state changes on rising edge.
- nrst  input  1  reset; asynchronous, active-low.
- din  input  32  load word, IEEE-754 single precision.
- din_valid  input  1  load word present.
- din_ready  output  1  load word accepted when din_valid and din_ready are both high.
- row_vec  output  32 x [7:0]  row i of A, sent to the engine.
- col_vec  output  32 x [7:0]  column j of B, sent to the engine.
- vec_valid  output  1  vector pair valid for one cycle; the engine cannot stall.
- res  input  32  dot-product result from the engine.
- res_valid  input  1  result present; results return in issue order.
- dout  output  32  C element.
- dout_valid  output  1  C element present.
- dout_ready  input  1  downstream accepts dout.
- dout_last  output  1  high together with the 64th C element.
- res_overflow  output  1  sticky error flag.

## Operation
- There are four states: LOAD, ISSUE, WAIT and DRAIN. Reset enters LOAD.
- **LOAD**
  - din_ready = 1.
  - The load counter ld_cnt (7 bits) counts accepted words.
  - Words 0–63 fill A in row-major order: A[ld_cnt>>3][ld_cnt&7].
  - Words 64–127 fill B in row-major order.
  - On the accept with ld_cnt = 127, the block goes to ISSUE and ld_cnt returns to 0.
  - Gaps in din_valid are allowed.
- **ISSUE**
  - The issue counter k runs 0..63, one step per cycle, with no gaps.
  - For each k: row_vec[n] = A[k>>3][n], col_vec[n] = B[n][k&7], vec_valid = 1.
  - These outputs are registered.
  - After k = 63 the block goes to WAIT.
- **Result collection** (ISSUE and WAIT)
  - Each res_valid writes res into res_buf[rc], then rc increments. rc is 7 bits.
  - Results may arrive while ISSUE is still running.
- **WAIT**
  - When a write makes rc = 64, the block goes to DRAIN on the next cycle.
  - The same transition applies if the 64th result arrives during ISSUE: the block goes to DRAIN once k = 63 has been issued.
- **DRAIN**
  - dout_valid = 1, and dout = res_buf[rd] read combinationally.
  - rd advances on each dout_valid && dout_ready.
  - dout_last = (rd = 63).
  - After the last element is accepted, rd and rc clear and the block returns to LOAD.
- **Stray results**
  - A res_valid in LOAD or DRAIN, or a 65th result, is discarded.
  - That event sets res_overflow, which stays high until reset.
- **Arithmetic**
  - Data passes through unchanged.
  - Counters wrap only by explicit clear; none wraps naturally.

## Timing
- **Reset values**
  - din_ready = 1, because the state is LOAD.
  - vec_valid, dout_valid, dout_last and res_overflow = 0.
  - row_vec, col_vec and dout = 0.
  - All counters = 0.
  - A, B and res_buf contents are don't-care.
- **Reset mid-operation** (asynchronous): the block returns to LOAD immediately, and any partial block is abandoned.
- **Issue latency:** the first vec_valid comes 1 cycle after the clock edge that accepts word 127.
- **Issue duration:** vec_valid is high for exactly 64 consecutive cycles.
- **Drain start:** dout_valid rises 1 cycle after the edge that writes the 64th result.
- **Drain handshake:** with dout_ready held high, DRAIN lasts 64 cycles. dout and dout_last stay stable while dout_valid = 1 and dout_ready = 0.
- **Next block:** din_ready rises in the cycle after the last drain handshake.
- **Throughput:** one block per 128 + 64 + engine latency + 64 cycles, at minimum.

## Configuration
- Macro: MAT_MUL_SEQ_TRANSPOSE_EN.
- **Defined:** DRAIN emits C in column-major order, so dout = res_buf[{rd[2:0], rd[5:3]}] and C^T is streamed. This serves the second DCT pass.
- **Undefined:** DRAIN emits C in row-major order, so dout = res_buf[rd].
- dout_last timing is identical in both cases.

## Structure
Package mat_mul_seq_pkg holds:
- constant N = 8 and constant NN = 64;
- typedef fp32_t (logic [31:0]);
- typedef mat_t (fp32_t [N-1:0][N-1:0]);
- enum state_t {LOAD, ISSUE, WAIT, DRAIN}.

Sub-module mat_mul_seq_rbuf holds the 64 x 32 result buffer:
- one write port (we, waddr[5:0], wdata);
- one combinational read port (raddr[5:0], rdata);
- no reset on its contents.

The top level holds the FSM, the counters, and the A/B register arrays.

## Test plan
- **Identity product:** A = identity (1.0 = 0x3F800000), B[r][c] = float(8r+c), with an engine model of latency 10. Expect C = B, with dout_last on the 64th word (0x427C0000 = 63.0).
- **Transpose build:** same stimulus with MAT_MUL_SEQ_TRANSPOSE_EN defined. Expect dout sequence 0.0, 8.0, 16.0, … and the 64th word 63.0.
- **Load backpressure:** din_valid toggles on alternate cycles. Expect exactly 128 accepts; vec_valid rises 1 cycle after the 128th accept and stays high 64 cycles; row_vec for k = 9 is A row 1 and col_vec is B column 1.
- **Drain backpressure:** dout_ready is low for 3 cycles at rd = 5. Expect dout to hold the element-5 value, no element skipped or duplicated, and din_ready to rise only after the 64th handshake.
- **Reset mid-ISSUE:** assert nrst low at k = 20. Expect vec_valid = 0 and din_ready = 1 immediately. A fresh block then runs correctly, with no stale results.
- **Stray result:** pulse res_valid during LOAD. Expect res_overflow = 1, still high after a complete correct block, and cleared only by reset.
